// File: rtl/imem_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : imem_fetch_unit
// Description : Byte-addressed instruction memory with a request/response
//               fetch handshake, wait states, flush and fault reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_unit #(
  parameter int ADDR_WIDTH  = 64,
  parameter int DEPTH_BYTES = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data,
  output logic [1:0]            resp_fault,
  input  logic                  flush,
  input  logic                  ld_en,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [7:0]            ld_data
);

  localparam int                  c_IDX_W     = $clog2(DEPTH_BYTES);
  localparam logic [ADDR_WIDTH-1:0] c_DEPTH     = ADDR_WIDTH'(DEPTH_BYTES);
  localparam logic [ADDR_WIDTH-1:0] c_OOR_LIMIT = ADDR_WIDTH'(DEPTH_BYTES - 3);
  localparam logic [3:0]          c_CNT_INIT  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_cnt;
  logic [31:0]           r_resp_data;
  logic [1:0]            r_resp_fault;
  logic [7:0]            r_mem [0:DEPTH_BYTES-1];

  logic                  w_accept;
  logic                  w_enter_resp;
  logic [ADDR_WIDTH-1:0] w_src_addr;
  logic [1:0]            w_fault;
  logic [c_IDX_W-1:0]    w_idx0;
  logic [c_IDX_W-1:0]    w_idx1;
  logic [c_IDX_W-1:0]    w_idx2;
  logic [c_IDX_W-1:0]    w_idx3;
  logic [31:0]           w_word;

  assign req_ready  = (r_state == S_IDLE) & ~flush;
  assign resp_valid = (r_state == S_RESP);
  assign resp_data  = r_resp_data;
  assign resp_fault = r_resp_fault;

  assign w_accept = req_valid & req_ready;

  // With zero wait states the capture edge is the accept edge, so read straight from req_addr.
  assign w_enter_resp = ~flush & (((r_state == S_IDLE) & w_accept & (WAIT_STATES == 0)) |
                                  ((r_state == S_WAIT) & (r_cnt == 4'd0)));
  assign w_src_addr   = (r_state == S_IDLE) ? req_addr : r_addr;

  // Full-width compare so addresses near the top of the space never wrap into range.
  assign w_fault = {(w_src_addr >= c_OOR_LIMIT), (w_src_addr[1:0] != 2'b00)};

  assign w_idx0 = w_src_addr[c_IDX_W-1:0];
  assign w_idx1 = w_idx0 + c_IDX_W'(1);
  assign w_idx2 = w_idx0 + c_IDX_W'(2);
  assign w_idx3 = w_idx0 + c_IDX_W'(3);
  assign w_word = {r_mem[w_idx3], r_mem[w_idx2], r_mem[w_idx1], r_mem[w_idx0]};

  // Storage is deliberately not reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (ld_en && (ld_addr < c_DEPTH)) begin
      r_mem[ld_addr[c_IDX_W-1:0]] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_cnt        <= 4'd0;
      r_resp_data  <= 32'd0;
      r_resp_fault <= 2'b00;
    end else begin
      if (w_enter_resp) begin
        r_resp_data  <= (|w_fault) ? 32'd0 : w_word;
        r_resp_fault <= w_fault;
      end
      if (flush) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_addr  <= req_addr;
              r_cnt   <= c_CNT_INIT;
              r_state <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
            end
          end
          S_WAIT: begin
            if (r_cnt == 4'd0) begin
              r_state <= S_RESP;
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end
          S_RESP: begin
            if (resp_ready) begin
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
